// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: RV32M multiply/divide sequencer beside the ex-stage ALU.
// Iterative 32-step shift-add multiply and restoring divide on operand
// magnitudes, with sign correction applied when the result is registered.
// Division special cases complete in one cycle.
// Optional build macro MULDIV_FAST_MUL_EN: all multiply ops use a single
// 33x33 signed multiplier in the issue cycle and bypass the iteration.
module ex_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] dvs_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt;
  logic        neg_res_q;
  logic        neg_rem_q;

  logic        sgn1, sgn2, neg1, neg2;
  logic [31:0] mag1, mag2;
  logic        div_zero, div_ovf, special, accept;
  logic [31:0] special_res;

  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [63:0] div_nx;
  logic [63:0] step_nx;
  logic [63:0] prod_c;
  logic [31:0] quo_c, rem_c, calc_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [63:0] fast_prod;
`endif

  always_comb begin
    sgn1        = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn2        = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    neg1        = sgn1 & reg1_i[31];
    neg2        = sgn2 & reg2_i[31];
    mag1        = neg1 ? (~reg1_i + 32'd1) : reg1_i;
    mag2        = neg2 ? (~reg2_i + 32'd1) : reg2_i;
    div_zero    = op_i[2] && (reg2_i == '0);
    div_ovf     = op_i[2] && !op_i[0] && (reg1_i == 32'h8000_0000) && (reg2_i == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = op_i[1] ? reg1_i : '1;
    else if (div_ovf)
      special_res = op_i[1] ? '0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {sgn1 & reg1_i[31], reg1_i};
    fast_b    = {sgn2 & reg2_i[31], reg2_i};
    fast_prod = 64'(fast_a) * 64'(fast_b);
    if (!op_i[2]) begin
      special     = 1'b1;
      special_res = (op_i[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
    accept = (state_q == IDLE) && start_i && !flush_i;
  end

  // acc_q holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    mul_nx   = {mul_sum, acc_q[31:1]};
    rem_sh   = acc_q[63:31];
    rem_ge   = rem_sh >= {1'b0, dvs_q};
    div_nx   = rem_ge ? {rem_sh[31:0] - dvs_q, acc_q[30:0], 1'b1}
                      : {rem_sh[31:0], acc_q[30:0], 1'b0};
    step_nx  = op_q[2] ? div_nx : mul_nx;
    prod_c   = neg_res_q ? (~step_nx + 64'd1) : step_nx;
    quo_c    = neg_res_q ? (~step_nx[31:0] + 32'd1) : step_nx[31:0];
    rem_c    = neg_rem_q ? (~step_nx[63:32] + 32'd1) : step_nx[63:32];
    calc_res = '0;
    case (op_q)
      3'b000:                 calc_res = prod_c[31:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_c[63:32];
      3'b100, 3'b101:         calc_res = quo_c;
      default:                calc_res = rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
          stall_o = !special;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (cnt == 5'd31)
          state_d = DONE;
      end
      DONE: begin
        done_o  = !flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      dvs_q     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
    end else if (accept) begin
      op_q      <= op_i;
      dvs_q     <= mag2;
      acc_q     <= {32'd0, mag1};
      cnt       <= '0;
      neg_res_q <= neg1 ^ neg2;
      neg_rem_q <= neg1;
      if (special)
        result_o <= special_res;
    end else if ((state_q == CALC) && !flush_i) begin
      acc_q <= step_nx;
      cnt   <= cnt + 5'd1;
      if (cnt == 5'd31)
        result_o <= calc_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: directed and random RV32M operations,
// flush and asynchronous-reset abort scenarios.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  ex_muldiv_ctrl #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .reg1_i   (reg1_i),
    .reg2_i   (reg2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb_, p;
    longint unsigned ua, ub, pu;
    logic            ovf;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb_; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb_; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the edge following done.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit   sp;
    int   n;
    exp_t e;
    sp      = is_special(op, a, b);
    start_i = 1'b1;
    op_i    = op;
    reg1_i  = a;
    reg2_i  = b;
    e.res   = ref_model(op, a, b);
    e.due   = cyc + (sp ? 1 : 33);
    e.op    = op;
    sb.push_back(e);
    last_res = e.res;
    #1;
    check("stall_at_issue", {31'd0, stall_o}, {31'd0, !sp});
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout: op %0d gave no done_o within 100 cycles", op);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst && done_o) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", result_o, mon_e.res);
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd7, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b);
    end

    // Flush a divide mid-iteration, then restart immediately.
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_i = 1'b1; op_i = 3'd4; reg1_i = 32'd1000; reg2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_result_hold", result_o, last_res);
    check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    issue(3'd5, 32'd1000, 32'd3);

    // Asynchronous reset in the middle of a divide.
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_i = 1'b1; op_i = 3'd4; reg1_i = 32'd12345; reg2_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    check("abort_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
